// File: rtl/count8_down_timer.sv
// rtl/count8_down_timer.sv - loadable down-counting timer with terminal-count pulse and sticky done
// Optional prescaler compiled in with `define COUNT8_DOWN_PRESCALE_EN.
module count8_down_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   input  logic             load,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             tick;

`ifdef COUNT8_DOWN_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] presc_run;

   // With PRESCALE=1 the counter sits at 0 and every RUN cycle ticks.
   assign tick      = (presc_q == PW'(PRESCALE - 1));
   assign presc_run = tick ? '0 : presc_q + PW'(1);
`else
   // PRESCALE is legal only when >= 1; without the prescaler every RUN cycle ticks.
   assign tick = (PRESCALE >= 1);
`endif

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      reload_d = reload_q;
      busy_d   = busy_q;
      tc_d     = 1'b0;
      done_d   = done_q;
`ifdef COUNT8_DOWN_PRESCALE_EN
      presc_d  = presc_q;
`endif
      if (load) begin
         state_d  = S_IDLE;
         out_d    = data;
         reload_d = data;
         busy_d   = 1'b0;
         done_d   = 1'b0;
`ifdef COUNT8_DOWN_PRESCALE_EN
         presc_d  = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (out_q == '0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     tc_d    = 1'b1;
                  end else begin
                     state_d = S_RUN;
                     busy_d  = 1'b1;
                     done_d  = 1'b0;
`ifdef COUNT8_DOWN_PRESCALE_EN
                     presc_d = '0;
`endif
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  state_d = S_HOLD;
               end else begin
`ifdef COUNT8_DOWN_PRESCALE_EN
                  presc_d = presc_run;
`endif
                  if (tick) begin
                     if (out_q > WIDTH'(1)) begin
                        out_d = out_q - WIDTH'(1);
                     end else if (auto_reload && (reload_q != '0)) begin
                        out_d = reload_q;
                        tc_d  = 1'b1;
                     end else begin
                        out_d   = '0;
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (start && !stop) begin
                  state_d = S_RUN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         out_q    <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         tc_q     <= 1'b0;
         done_q   <= 1'b0;
`ifdef COUNT8_DOWN_PRESCALE_EN
         presc_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         tc_q     <= tc_d;
         done_q   <= done_d;
`ifdef COUNT8_DOWN_PRESCALE_EN
         presc_q  <= presc_d;
`endif
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign tc   = tc_q;
   assign done = done_q;

endmodule

// File: tb/tb_count8_down_timer.sv
// tb/tb_count8_down_timer.sv - self-checking bench for count8_down_timer
module tb_count8_down_timer;

`ifdef COUNT8_DOWN_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = '0;
   logic       ld = 1'b0, st = 1'b0, sp = 1'b0, ar = 1'b0;
   logic [7:0] dut_out;
   logic       dut_busy, dut_tc, dut_done;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   count8_down_timer #(.WIDTH(8), .PRESCALE(4)) dut (
      .clk(clk), .rst(rst), .data(data), .load(ld), .start(st), .stop(sp),
      .auto_reload(ar), .out(dut_out), .busy(dut_busy), .tc(dut_tc), .done(dut_done)
   );

   // Reference model: phase 0=idle 1=running 2=paused 3=finished
   int m_out, m_rld, m_ph, m_busy, m_tc, m_done, m_sub;

   task automatic model_reset();
      m_out = 0; m_rld = 0; m_ph = 0; m_busy = 0; m_tc = 0; m_done = 0; m_sub = 0;
   endtask

   task automatic model_step();
      m_tc = 0;
      if (ld) begin
         m_out = data; m_rld = data; m_ph = 0; m_busy = 0; m_done = 0; m_sub = 0;
      end else if (m_ph == 1 && sp) begin
         m_ph = 2;
      end else if (m_ph == 0 || m_ph == 3) begin
         if (st && m_out == 0) begin
            m_ph = 3; m_done = 1; m_tc = 1;
         end else if (st) begin
            m_ph = 1; m_busy = 1; m_done = 0; m_sub = 0;
         end
      end else if (m_ph == 2) begin
         if (st && !sp) m_ph = 1;
      end else begin
         m_sub = m_sub + 1;
         if (m_sub == PS) begin
            m_sub = 0;
            if (m_out >= 2) m_out = m_out - 1;
            else if (ar && m_rld != 0) begin
               m_out = m_rld; m_tc = 1;
            end else begin
               m_out = 0; m_tc = 1; m_done = 1; m_busy = 0; m_ph = 3;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic l, input logic s, input logic p, input logic a, input logic [7:0] d);
      ld = l; st = s; sp = p; ar = a; data = d;
      @(posedge clk);
      model_step();
      #1;
      chk("model_out", dut_out, m_out);
      chk("model_busy", dut_busy, m_busy);
      chk("model_tc", dut_tc, m_tc);
      chk("model_done", dut_done, m_done);
   endtask

   typedef struct {
      logic       ld, st, sp, ar;
      logic [7:0] d;
      int         e_out, e_busy, e_tc, e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic l, input logic s, input logic p, input logic a,
                               input logic [7:0] d, input int eo, input int eb, input int et, input int ed);
      vec_t v;
      v.ld = l; v.st = s; v.sp = p; v.ar = a; v.d = d;
      v.e_out = eo; v.e_busy = eb; v.e_tc = et; v.e_done = ed;
      vecs.push_back(v);
   endfunction

   initial begin
      model_reset();
      // load 3, start: 3,2,1,0 with tc on the final edge
      add(1,0,0,0,3,   3,0,0,0);
      add(0,1,0,0,0,   3,1,0,0);
      add(0,0,0,0,0,   2,1,0,0);
      add(0,0,0,0,0,   1,1,0,0);
      add(0,0,0,0,0,   0,0,1,1);
      add(0,0,0,0,0,   0,0,0,1);
      // load 5, pause at 3, hold, resume
      add(1,0,0,0,5,   5,0,0,0);
      add(0,1,0,0,0,   5,1,0,0);
      add(0,0,0,0,0,   4,1,0,0);
      add(0,0,0,0,0,   3,1,0,0);
      add(0,0,1,0,0,   3,1,0,0);
      add(0,0,0,0,0,   3,1,0,0);
      add(0,1,1,0,0,   3,1,0,0);
      add(0,0,0,0,0,   3,1,0,0);
      add(0,1,0,0,0,   3,1,0,0);
      add(0,0,0,0,0,   2,1,0,0);
      add(0,0,0,0,0,   1,1,0,0);
      add(0,0,0,0,0,   0,0,1,1);
      add(0,0,0,0,0,   0,0,0,1);
      // zero count: immediate finish, then load+start together only loads
      add(1,0,0,0,0,   0,0,0,0);
      add(0,1,0,0,0,   0,0,1,1);
      add(0,0,0,0,0,   0,0,0,1);
      add(1,1,0,0,16,  16,0,0,0);
      add(0,0,0,0,0,   16,0,0,0);
      // auto reload period 4
      add(1,0,0,1,4,   4,0,0,0);
      add(0,1,0,1,0,   4,1,0,0);
      for (int k = 0; k < 3; k++) begin
         add(0,0,0,1,0, 3,1,0,0);
         add(0,0,0,1,0, 2,1,0,0);
         add(0,0,0,1,0, 1,1,0,0);
         add(0,0,0,1,0, 4,1,1,0);
      end
      add(0,0,0,1,0,   3,1,0,0);
      // start while running is ignored; stop+start from idle starts
      add(1,0,0,0,2,   2,0,0,0);
      add(0,1,0,0,0,   2,1,0,0);
      add(0,1,0,0,0,   1,1,0,0);
      add(0,0,0,0,0,   0,0,1,1);
      add(1,0,0,0,1,   1,0,0,0);
      add(0,1,1,0,0,   1,1,0,0);
      add(0,0,0,0,0,   0,0,1,1);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out", dut_out, 0);
      chk("reset_busy", dut_busy, 0);
      chk("reset_tc", dut_tc, 0);
      chk("reset_done", dut_done, 0);

`ifdef COUNT8_DOWN_PRESCALE_EN
      cyc(1,0,0,0,2);
      cyc(0,1,0,0,0);
      for (int i = 1; i <= 9; i++) begin
         cyc(0,0,0,0,0);
         if (i == 3) chk("ps_out_n3", dut_out, 2);
         if (i == 4) chk("ps_out_n4", dut_out, 1);
         if (i == 7) chk("ps_tc_n7", dut_tc, 0);
         if (i == 8) begin
            chk("ps_out_n8", dut_out, 0);
            chk("ps_tc_n8", dut_tc, 1);
            chk("ps_done_n8", dut_done, 1);
         end
         if (i == 9) chk("ps_tc_n9", dut_tc, 0);
      end
`else
      foreach (vecs[i]) begin
         cyc(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].ar, vecs[i].d);
         chk($sformatf("vec%0d_out", i), dut_out, vecs[i].e_out);
         chk($sformatf("vec%0d_busy", i), dut_busy, vecs[i].e_busy);
         chk($sformatf("vec%0d_tc", i), dut_tc, vecs[i].e_tc);
         chk($sformatf("vec%0d_done", i), dut_done, vecs[i].e_done);
      end
`endif

      // asynchronous reset in the middle of a run
      cyc(1,0,0,0,8'h40);
      cyc(0,1,0,0,0);
      cyc(0,0,0,0,0);
      cyc(0,0,0,0,0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out", dut_out, 0);
      chk("async_rst_busy", dut_busy, 0);
      chk("async_rst_tc", dut_tc, 0);
      chk("async_rst_done", dut_done, 0);
      model_reset();
      rst = 1'b0;

      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
